axi_wr_slave_burst: RTL
=======================

Name: axi_wr_slave_burst

Overview:
Parametrised AXI4 write-channel slave that converts AW/W/B bursts into single-word local writes for the FIR register/coefficient space.
Successor of the single-purpose write slave, with these additions:
- configurable AXI data, address and length widths and local word/address widths
- FIXED/INCR bursts with narrow-transfer lane selection and per-beat local byte strobes
- address-range checking with SLVERR responses
Sits between the AXI interconnect and the FIR local register/memory write port.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 64, AXI write data width (power of 2, >= LOC_W)
LEN_W, 8, awlen width (AXI4)
LOC_W, 16, local data word width (power of 2, >= 8)
LOC_ADDR_W, 13, local word address width
BASE_ADDR, 0, byte address mapped to local word 0

Ports:
a_clk  in  1  clock; all logic rising-edge
a_rst  in  1  reset, asynchronous, active-high
awvalid  in  1  write address valid
awaddr  in  ADDR_W  burst start byte address
awlen  in  LEN_W  beats minus one
awsize  in  3  bytes per beat = 2^awsize
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awready  out  1  address accepted
wvalid  in  1  write data valid
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte strobes
wlast  in  1  last beat
wready  out  1  data accepted
bvalid  out  1  response valid
bresp  out  2  00 OKAY, 10 SLVERR
bready  in  1  response accepted
a_address_wr  out  LOC_ADDR_W  local word address
a_data_out  out  LOC_W  local write data
a_wstrb  out  LOC_W/8  local byte enables
a_wr  out  1  local write pulse
state_w_out  out  2  FSM state (debug): 0 IDLE, 1 DATA, 2 RESP

Behaviour:
- Reset (async, a_rst=1): state IDLE; awready=1; wready=0; bvalid=0; bresp=00; a_wr=0; a_address_wr=0; a_data_out=0; a_wstrb=0; err flag and beat counter cleared. Reset mid-burst drops the burst silently; no B response is issued.
- IDLE: awready=1. On awvalid&awready, latch addr/len/size/burst, clear beat counter and error, go to DATA next cycle. Accept check:
  - awsize > log2(LOC_W/8) -> set err
  - awburst=11 -> set err
  - WRAP without the macro -> set err
- DATA: awready=0, wready=1. Each wvalid&wready is one beat.
  - Beat at address A is in range when BASE_ADDR <= A < BASE_ADDR + 2^LOC_ADDR_W*(LOC_W/8).
  - Write condition: in range, no err, beat count <= awlen, and any strobe set in the lane.
  - When the condition holds, the next cycle is registered with a_wr=1, a_address_wr=(A-BASE_ADDR)>>log2(LOC_W/8), a_data_out=wdata lane [(A mod DATA_W/8) aligned down to LOC_W/8] and a_wstrb = the matching wstrb bits. Narrow beats keep sub-word byte position via a_wstrb.
  - An out-of-range beat sets err and suppresses a_wr.
  - a_wr is a single-cycle pulse per beat, so back-to-back beats give a continuous a_wr.
  - Address update after each beat: FIXED keeps A; INCR adds 2^awsize; WRAP per the macro.
  - Length mismatch: wlast earlier than awlen+1 beats sets err and ends the burst. Beats beyond awlen+1 without wlast set err, are not written, and are drained until wlast.
  - wlast accepted -> RESP next cycle; wready=0.
- RESP: bvalid=1; bresp=10 if err else 00. On bready -> IDLE next cycle; bvalid drops; awready=1. bvalid holds until bready.
- Ordering: one outstanding burst; no AW acceptance in DATA/RESP. W data presented before AW is not accepted (wready=0 in IDLE).
- Widths: address arithmetic in ADDR_W, wraps modulo 2^ADDR_W; the beat counter is LEN_W+1 bits.

Optional Feature:
AXI_WRAP_BURST_EN:
- Defined: WRAP bursts are supported. Legal only for awlen in {1,3,7,15} and an aligned start. Wrap boundary = (awlen+1)*2^awsize. The address increments and wraps to the boundary-aligned base. An illegal WRAP sets err.
- Undefined: awburst=10 sets err; the burst is drained, with no a_wr and bresp=SLVERR.

Decomposition:
Package axi_pkg:
- burst enum (FIXED/INCR/WRAP/RSVD)
- resp constants (OKAY=2'b00, SLVERR=2'b10)
- write FSM state enum (IDLE/DATA/RESP)
- localparam helper for log2(bytes)
Sub-module axi_burst_addr_gen: next-address/wrap computation and range check, shared with a future read slave.

Test Plan:
- INCR, awaddr=0x0A, awlen=1, awsize=1, wdata 0xABCD then 0xBBDD with wlast, full strobes -> a_wr pulses at word 5 data 0xABCD and word 6 data 0xBBDD (lane-selected); bvalid, bresp=00; IDLE after bready.
- FIXED, awaddr=0x10, awlen=3, four beats with lane data 0x1111..0x4444 -> four a_wr pulses all at word 8; last a_data_out=0x4444; bresp=00.
- awaddr beyond space (BASE_ADDR+0x4000), awlen=0 -> no a_wr; bresp=10.
- INCR awlen=3 with wlast on beat 2 -> beats 1-2 written; burst ends; bresp=10. Repeat with a 5th beat carrying wlast -> beat 5 not written; bresp=10.
- Narrow write awsize=0, awaddr=0x21, wstrb=0x02 -> a_address_wr=0x10, a_wstrb=2'b10. Then bready held low 5 cycles -> bvalid stays 1 and awready stays 0.
- Assert a_rst in DATA after 1 of 4 beats -> outputs return to reset values immediately; no bvalid; a new burst completes normally. With AXI_WRAP_BURST_EN, WRAP awaddr=0x0C, awlen=3, awsize=1 -> words 6,7,4,5.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI write-slave types and constants
// Purpose: burst and FSM state enums, response codes, byte-width log2 helper.
// Ports: none (package).
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } wr_state_e;

  // log2 of the number of bytes in a word of width_bits bits
  function automatic int log2_bytes(input int width_bits);
    return $clog2(width_bits / 8);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - AXI burst next-address and local range check
// Purpose: computes the address of the following beat (FIXED/INCR, WRAP when
//   AXI_WRAP_BURST_EN is defined), checks the current address against the
//   local window and converts it to a local word address.
// Ports:
//   addr_i      current beat byte address
//   size_i      log2 bytes per beat
//   burst_i     burst type
//   len_i       beats minus one (wrap boundary)
//   next_addr_o address of the next beat
//   in_range_o  current address lies inside the local window
//   word_addr_o local word address of the current beat
// Macro: AXI_WRAP_BURST_EN enables WRAP address generation.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              LEN_W      = 8,
  parameter int              LOC_W      = 16,
  parameter int              LOC_ADDR_W = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic [ADDR_W-1:0]     next_addr_o,
  output logic                  in_range_o,
  output logic [LOC_ADDR_W-1:0] word_addr_o
);

  localparam int         LOC_OFF     = log2_bytes(LOC_W);
  localparam logic [63:0] SPACE_BYTES = 64'(LOC_W / 8) << LOC_ADDR_W;

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] offset;

  always_comb begin
    incr   = ADDR_W'(1) << size_i;
    offset = addr_i - BASE_ADDR;
  end

  // offset is only meaningful when addr_i >= BASE_ADDR; the first term guards it
  assign in_range_o  = (addr_i >= BASE_ADDR) && (64'(offset) < SPACE_BYTES);
  assign word_addr_o = LOC_ADDR_W'(offset >> LOC_OFF);

`ifdef AXI_WRAP_BURST_EN
  logic [ADDR_W-1:0] wrap_mask;
  // wrap window is (len+1) beats of 2^size bytes; legality is checked by the caller
  assign wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  always_comb begin
    next_addr_o = addr_i + incr;
    case (burst_e'(burst_i))
      BURST_FIXED: next_addr_o = addr_i;
`ifdef AXI_WRAP_BURST_EN
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + incr) & wrap_mask);
`endif
      default:     next_addr_o = addr_i + incr;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave_burst.sv
// rtl/axi_wr_slave_burst.sv - AXI4 write burst slave to single-word local writes
// Purpose: accepts one AW/W/B burst at a time and issues one registered local
//   write per in-range beat, selecting the addressed LOC_W lane of wdata.
// Ports:
//   a_clk, a_rst                 clock, async active-high reset
//   awvalid/awaddr/awlen/awsize/awburst/awready   address channel
//   wvalid/wdata/wstrb/wlast/wready               data channel
//   bvalid/bresp/bready                           response channel
//   a_address_wr/a_data_out/a_wstrb/a_wr          local write port
//   state_w_out                                   FSM state for debug
// Macro: AXI_WRAP_BURST_EN enables WRAP bursts (otherwise WRAP -> SLVERR).
module axi_wr_slave_burst
  import axi_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 64,
  parameter int                LEN_W      = 8,
  parameter int                LOC_W      = 16,
  parameter int                LOC_ADDR_W = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                  a_clk,
  input  logic                  a_rst,
  input  logic                  awvalid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [LEN_W-1:0]      awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  output logic                  awready,
  input  logic                  wvalid,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  output logic                  wready,
  output logic                  bvalid,
  output logic [1:0]            bresp,
  input  logic                  bready,
  output logic [LOC_ADDR_W-1:0] a_address_wr,
  output logic [LOC_W-1:0]      a_data_out,
  output logic [LOC_W/8-1:0]    a_wstrb,
  output logic                  a_wr,
  output logic [1:0]            state_w_out
);

  localparam int LOC_BYTES  = LOC_W / 8;
  localparam int DATA_BYTES = DATA_W / 8;
  localparam int LOC_OFF    = log2_bytes(LOC_W);
  localparam int DB_W       = $clog2(DATA_W);
  localparam int SB_W       = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int CNT_W      = LEN_W + 1;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(DATA_BYTES - LOC_BYTES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  wr_state_e             state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [LEN_W-1:0]      len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  err_q;
  logic                  awready_q, wready_q, bvalid_q, a_wr_q;
  logic [1:0]            bresp_q;
  logic [LOC_ADDR_W-1:0] a_addr_q;
  logic [LOC_W-1:0]      a_data_q;
  logic [LOC_BYTES-1:0]  a_wstrb_q;

  logic [ADDR_W-1:0]     next_addr;
  logic                  in_range;
  logic [LOC_ADDR_W-1:0] word_addr;

  axi_burst_addr_gen #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .LOC_W     (LOC_W),
    .LOC_ADDR_W(LOC_ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .addr_i     (addr_q),
    .size_i     (size_q),
    .burst_i    (burst_q),
    .len_i      (len_q),
    .next_addr_o(next_addr),
    .in_range_o (in_range),
    .word_addr_o(word_addr)
  );

  // Burst-level legality, evaluated on the AW handshake
  logic accept_err;
  always_comb begin
    accept_err = (awsize > 3'(LOC_OFF)) || (burst_e'(awburst) == BURST_RSVD);
`ifdef AXI_WRAP_BURST_EN
    if (burst_e'(awburst) == BURST_WRAP) begin
      if (!((awlen == LEN_W'(1)) || (awlen == LEN_W'(3)) ||
            (awlen == LEN_W'(7)) || (awlen == LEN_W'(15))))
        accept_err = 1'b1;
      if ((awaddr & ((ADDR_W'(1) << awsize) - ADDR_W'(1))) != '0)
        accept_err = 1'b1;
    end
`else
    if (burst_e'(awburst) == BURST_WRAP)
      accept_err = 1'b1;
`endif
  end

  // Lane of wdata holding the addressed local word (byte offset aligned down to LOC_BYTES)
  logic [DB_W-1:0]      lane_bit;
  logic [SB_W-1:0]      lane_byte;
  logic [LOC_W-1:0]     lane_data;
  logic [LOC_BYTES-1:0] lane_strb;
  always_comb begin
    lane_byte = SB_W'(addr_q & LANE_MASK);
    lane_bit  = DB_W'(addr_q & LANE_MASK) << 3;
    lane_data = wdata[lane_bit +: LOC_W];
    lane_strb = wstrb[lane_byte +: LOC_BYTES];
  end

  logic beyond, early, beat_err_d, do_write;
  always_comb begin
    beyond     = cnt_q > {1'b0, len_q};
    early      = wlast && (cnt_q < {1'b0, len_q});
    beat_err_d = err_q || !in_range || beyond || early;
    // err_q (not beat_err_d) gates the write so an early-wlast beat is still written
    do_write   = in_range && !err_q && !beyond && (|lane_strb);
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      a_wr_q    <= 1'b0;
      a_addr_q  <= '0;
      a_data_q  <= '0;
      a_wstrb_q <= '0;
    end else begin
      a_wr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (awvalid && awready_q) begin
            addr_q    <= awaddr;
            len_q     <= awlen;
            size_q    <= awsize;
            burst_q   <= awburst;
            cnt_q     <= '0;
            err_q     <= accept_err;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wvalid && wready_q) begin
            addr_q <= next_addr;
            if (cnt_q != CNT_MAX)
              cnt_q <= cnt_q + CNT_W'(1);
            err_q <= beat_err_d;
            if (do_write) begin
              a_wr_q    <= 1'b1;
              a_addr_q  <= word_addr;
              a_data_q  <= lane_data;
              a_wstrb_q <= lane_strb;
            end
            if (wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= beat_err_d ? RESP_SLVERR : RESP_OKAY;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          awready_q <= 1'b1;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign a_wr         = a_wr_q;
  assign a_address_wr = a_addr_q;
  assign a_data_out   = a_data_q;
  assign a_wstrb      = a_wstrb_q;
  assign state_w_out  = state_q;

endmodule
